// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus: receive-FIFO pop side plus decoded key event outputs.
interface ps2_key_decoder_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic [7:0] key_held;
    logic       seq_err;

    modport slave (
        input  fifo_empty, fifo_data,
        output fifo_rd, key_code, key_ext, key_break, key_valid, key_held, seq_err
    );

    modport master (
        output fifo_empty, fifo_data,
        input  fifo_rd, key_code, key_ext, key_break, key_valid, key_held, seq_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// Set-2 scancode decoder: strips E0/F0 prefixes, swallows Pause, emits one
// make/break event per key and tracks the eight game keys as a held bitmap.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYC     = 2500000,
    parameter bit          REPEAT_SUPPRESS = 1'b1
) (
    input logic              clk,
    input logic              rst,
    ps2_key_decoder_if.slave bus
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_PAUSE   = 3'd4;

    localparam logic [0:0] P_FETCH = 1'b0;
    localparam logic [0:0] P_GAP   = 1'b1;

    logic [2:0]    state_q, state_d;
    logic [0:0]    pop_q, pop_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    code_q;
    logic          ext_q, brk_q, valid_q, err_q, err_d;
    logic [7:0]    held_q, held_d;

    logic       sample;
    logic [7:0] b;
    logic       is_prefix, ignorable;
    logic       emit, emit_ext, emit_brk, tmo_hit;
    logic       map_hit, suppress, fire;
    logic [2:0] map_idx;

    // Pop strobe is gated by reset so nothing leaves the FIFO while held in reset.
    assign sample = rst & (pop_q == P_FETCH) & ~bus.fifo_empty;
    assign pop_d  = sample ? P_GAP : P_FETCH;
    assign b      = bus.fifo_data;

    assign is_prefix = (b == 8'hE0) || (b == 8'hE1) || (b == 8'hF0);

    always_comb begin
        ignorable = 1'b0;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ignorable = 1'b1;
            default: ignorable = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        err_d    = 1'b0;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        tmo_hit  = 1'b0;
        if (sample) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (b == 8'hE0)      state_d = S_EXT;
                    else if (b == 8'hF0) state_d = S_BRK;
                    else if (b == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else if (!ignorable) emit = 1'b1;
                end
                S_EXT: begin
                    state_d = S_IDLE;
                    if (b == 8'hF0)    state_d = S_EXT_BRK;
                    else if (is_prefix) err_d  = 1'b1;
                    else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_prefix) err_d = 1'b1;
                    else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = (state_q == S_EXT_BRK);
                    end
                end
                S_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // A byte landing in the expiry cycle takes the sample branch instead.
            if (tmo_q == TMO_LAST) begin
                tmo_hit = 1'b1;
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_comb begin
        map_hit = 1'b1;
        map_idx = 3'd0;
        case ({emit_ext, b})
            9'h16B:  map_idx = 3'd0;
            9'h174:  map_idx = 3'd1;
            9'h172:  map_idx = 3'd2;
            9'h175:  map_idx = 3'd3;
            9'h029:  map_idx = 3'd4;
            9'h05A:  map_idx = 3'd5;
            9'h076:  map_idx = 3'd6;
            9'h04D:  map_idx = 3'd7;
            default: map_hit = 1'b0;
        endcase
    end

    assign suppress = REPEAT_SUPPRESS && emit && !emit_brk && map_hit && held_q[map_idx];
    assign fire     = emit && !suppress;

    always_comb begin
        held_d = held_q;
        if (fire && map_hit) held_d[map_idx] = !emit_brk;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pop_q   <= P_FETCH;
            skip_q  <= '0;
            tmo_q   <= '0;
            code_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            valid_q <= fire;
            err_q   <= err_d;
            held_q  <= held_d;
            if (fire) begin
                code_q <= b;
                ext_q  <= emit_ext;
                brk_q  <= emit_brk;
            end
        end
    end

    assign bus.fifo_rd   = sample;
    assign bus.key_code  = code_q;
    assign bus.key_ext   = ext_q;
    assign bus.key_break = brk_q;
    assign bus.key_valid = valid_q;
    assign bus.key_held  = held_q;
    assign bus.seq_err   = err_q | tmo_hit;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: two decoders (repeat suppression on/off) fed from queue FIFOs.
module tb_ps2_key_decoder;
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] held;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ps2_key_decoder_if ifa();
    ps2_key_decoder_if ifb();

    ps2_key_decoder #(.TIMEOUT_CYC(16), .REPEAT_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(ifa));
    ps2_key_decoder #(.TIMEOUT_CYC(16), .REPEAT_SUPPRESS(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .bus(ifb));

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    ev_t        expa[$];
    ev_t        expb[$];
    int cyc = 0, rd_cyc = 0, val_cyc = 0;
    int eva = 0, evb = 0, sea = 0, rda = 0;
    bit rd_a, rd_b;

    // FWFT FIFO models; outputs only change 1 time unit after the rising edge.
    initial begin
        ifa.fifo_empty = 1'b1; ifa.fifo_data = 8'h00;
        ifb.fifo_empty = 1'b1; ifb.fifo_data = 8'h00;
        forever begin
            @(negedge clk);
            rd_a = ifa.fifo_rd;
            rd_b = ifb.fifo_rd;
            @(posedge clk);
            #1;
            if (rd_a && qa.size() > 0) qa.delete(0);
            if (rd_b && qb.size() > 0) qb.delete(0);
            ifa.fifo_empty = (qa.size() == 0);
            ifa.fifo_data  = (qa.size() > 0) ? qa[0] : 8'h00;
            ifb.fifo_empty = (qb.size() == 0);
            ifb.fifo_data  = (qb.size() > 0) ? qb[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (ifa.fifo_rd) begin rda++; rd_cyc = cyc; end
        if (ifa.seq_err) sea++;
        if (rst && ifa.key_valid) begin
            val_cyc = cyc;
            eva++;
            checks++;
            if (expa.size() == 0) begin
                errors++;
                $display("FAIL event_a unexpected: code=%h ext=%b brk=%b held=%h", ifa.key_code, ifa.key_ext, ifa.key_break, ifa.key_held);
            end else begin
                e = expa.pop_front();
                if ({ifa.key_code, ifa.key_ext, ifa.key_break, ifa.key_held} !== e) begin
                    errors++;
                    $display("FAIL event_a: got code=%h ext=%b brk=%b held=%h want code=%h ext=%b brk=%b held=%h",
                             ifa.key_code, ifa.key_ext, ifa.key_break, ifa.key_held, e.code, e.ext, e.brk, e.held);
                end
            end
        end
        if (rst && ifb.key_valid) begin
            evb++;
            checks++;
            if (expb.size() == 0) begin
                errors++;
                $display("FAIL event_b unexpected: code=%h ext=%b brk=%b held=%h", ifb.key_code, ifb.key_ext, ifb.key_break, ifb.key_held);
            end else begin
                e = expb.pop_front();
                if ({ifb.key_code, ifb.key_ext, ifb.key_break, ifb.key_held} !== e) begin
                    errors++;
                    $display("FAIL event_b: got code=%h ext=%b brk=%b held=%h want code=%h ext=%b brk=%b held=%h",
                             ifb.key_code, ifb.key_ext, ifb.key_break, ifb.key_held, e.code, e.ext, e.brk, e.held);
                end
            end
        end
    end

    task automatic push_a(input logic [7:0] v);
        qa.push_back(v);
    endtask

    task automatic expect_a(input logic [7:0] c, input logic x, input logic k, input logic [7:0] h);
        ev_t e;
        e = '{code: c, ext: x, brk: k, held: h};
        expa.push_back(e);
    endtask

    task automatic settle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && ifa.fifo_empty && ifb.fifo_empty && !ifa.fifo_rd && !ifb.fifo_rd) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (ifa.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifa.key_valid); end
        checks++; if (ifa.key_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h want 00", ifa.key_code); end
        checks++; if (ifa.key_held !== 8'h00) begin errors++; $display("FAIL reset_held: got %h want 00", ifa.key_held); end
        checks++; if ({ifa.key_ext, ifa.key_break, ifa.seq_err, ifa.fifo_rd} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {ifa.key_ext, ifa.key_break, ifa.seq_err, ifa.fifo_rd});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        bit ok;
        int rd0 = rda, ev0 = eva;
        push_a(8'h1C); expect_a(8'h1C, 1'b0, 1'b0, 8'h00);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL single_drain: got pending=%0d want 0", expa.size()); end
        checks++; if (rda - rd0 != 1) begin errors++; $display("FAIL single_pops: got %0d want 1", rda - rd0); end
        checks++; if (eva - ev0 != 1) begin errors++; $display("FAIL single_events: got %0d want 1", eva - ev0); end
        checks++; if (val_cyc - rd_cyc != 1) begin errors++; $display("FAIL single_latency: got %0d want 1", val_cyc - rd_cyc); end
    endtask

    task automatic test_ext_arrow;
        bit ok;
        int ev0 = eva;
        push_a(8'hE0); push_a(8'h6B); expect_a(8'h6B, 1'b1, 1'b0, 8'h01);
        push_a(8'hE0); push_a(8'hF0); push_a(8'h6B); expect_a(8'h6B, 1'b1, 1'b1, 8'h00);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL ext_drain: got pending=%0d want 0", expa.size()); end
        checks++; if (eva - ev0 != 2) begin errors++; $display("FAIL ext_events: got %0d want 2", eva - ev0); end
    endtask

    task automatic test_repeat;
        bit ok;
        int ea0 = eva, eb0 = evb;
        logic [7:0] seq [5];
        ev_t e;
        seq = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
        foreach (seq[i]) begin qa.push_back(seq[i]); qb.push_back(seq[i]); end
        expect_a(8'h29, 1'b0, 1'b0, 8'h10);
        expect_a(8'h29, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            e = '{code: 8'h29, ext: 1'b0, brk: 1'b0, held: 8'h10};
            expb.push_back(e);
        end
        e = '{code: 8'h29, ext: 1'b0, brk: 1'b1, held: 8'h00};
        expb.push_back(e);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0 || expb.size() != 0) begin
            errors++; $display("FAIL repeat_drain: got pending=%0d/%0d want 0/0", expa.size(), expb.size());
        end
        checks++; if (eva - ea0 != 2) begin errors++; $display("FAIL repeat_suppressed_events: got %0d want 2", eva - ea0); end
        checks++; if (evb - eb0 != 4) begin errors++; $display("FAIL repeat_passed_events: got %0d want 4", evb - eb0); end
    endtask

    task automatic test_ignore_malformed;
        bit ok;
        int ev0 = eva, se0 = sea;
        logic [7:0] seq [13];
        seq = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE0, 8'hE1, 8'hF0, 8'hE0, 8'hE0, 8'hF0, 8'h75};
        foreach (seq[i]) push_a(seq[i]);
        push_a(8'h45);
        expect_a(8'h75, 1'b1, 1'b1, 8'h00);
        expect_a(8'h45, 1'b0, 1'b0, 8'h00);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL malformed_drain: got pending=%0d want 0", expa.size()); end
        checks++; if (eva - ev0 != 2) begin errors++; $display("FAIL malformed_events: got %0d want 2", eva - ev0); end
        checks++; if (sea - se0 != 2) begin errors++; $display("FAIL malformed_seq_err: got %0d want 2", sea - se0); end
    endtask

    task automatic test_pause;
        bit ok;
        int ev0 = eva, se0 = sea;
        logic [7:0] seq [9];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};
        foreach (seq[i]) push_a(seq[i]);
        expect_a(8'h5A, 1'b0, 1'b0, 8'h20);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL pause_drain: got pending=%0d want 0", expa.size()); end
        checks++; if (eva - ev0 != 1) begin errors++; $display("FAIL pause_events: got %0d want 1", eva - ev0); end
        checks++; if (sea - se0 != 0) begin errors++; $display("FAIL pause_seq_err: got %0d want 0", sea - se0); end
    endtask

    task automatic test_timeout;
        bit ok, found;
        logic se [17];
        found = 1'b0;
        push_a(8'hF0);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifa.fifo_rd && ifa.fifo_data == 8'hF0) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL timeout_pop: got no F0 pop want pop"); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            se[k] = ifa.seq_err;
        end
        checks++; if (se[14] !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0 at cycle 14", se[14]); end
        checks++; if (se[15] !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1 at cycle 15", se[15]); end
        checks++; if (se[16] !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b want 0 at cycle 16", se[16]); end
        push_a(8'h76); expect_a(8'h76, 1'b0, 1'b0, 8'h60);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL timeout_recover: got pending=%0d want 0", expa.size()); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [6:0] pat;
        push_a(8'h16); push_a(8'h1E); push_a(8'h26); push_a(8'h25);
        expect_a(8'h16, 1'b0, 1'b0, 8'h60);
        expect_a(8'h1E, 1'b0, 1'b0, 8'h60);
        expect_a(8'h26, 1'b0, 1'b0, 8'h60);
        expect_a(8'h25, 1'b0, 1'b0, 8'h60);
        for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            pat[i] = ifa.fifo_rd;
        end
        checks++; if (pat !== 7'b1010101) begin errors++; $display("FAIL b2b_rd_pattern: got %b want 1010101", pat); end
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL b2b_drain: got pending=%0d want 0", expa.size()); end
    endtask

    task automatic test_reset_mid_seq;
        bit ok, found;
        found = 1'b0;
        push_a(8'hE0);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ifa.fifo_rd && ifa.fifo_data == 8'hE0) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_mid_pop: got no E0 pop want pop"); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ifa.key_held !== 8'h00) begin errors++; $display("FAIL rst_mid_held: got %h want 00", ifa.key_held); end
        checks++; if (ifa.key_code !== 8'h00) begin errors++; $display("FAIL rst_mid_code: got %h want 00", ifa.key_code); end
        checks++; if ({ifa.key_valid, ifa.key_ext, ifa.key_break, ifa.seq_err, ifa.fifo_rd} !== 5'b0) begin
            errors++; $display("FAIL rst_mid_flags: got %b want 00000", {ifa.key_valid, ifa.key_ext, ifa.key_break, ifa.seq_err, ifa.fifo_rd});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_a(8'h74); expect_a(8'h74, 1'b0, 1'b0, 8'h00);
        settle(ok);
        checks++; if (ok !== 1'b1 || expa.size() != 0) begin errors++; $display("FAIL rst_mid_stray: got pending=%0d want 0", expa.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_ext_arrow;
        test_repeat;
        test_ignore_malformed;
        test_pause;
        test_timeout;
        test_back_to_back;
        test_reset_mid_seq;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion by 200000");
        $fatal(1);
    end
endmodule
